// File: rtl/terminal_pkg.sv
// Shared definitions for the text-terminal writer: FSM states, control codes
// and the screen geometry the terminal RAM is built around.
package terminal_pkg;

    localparam int          SCREEN_COLUMNS    = 80;
    localparam int          SCREEN_ROWS       = 30;
    localparam int          SCREEN_ADDR_WIDTH = 12;
    localparam logic [7:0]  BLANK_CHAR        = 8'h20;

    localparam logic [7:0]  CHAR_LF  = 8'h0A;
    localparam logic [7:0]  CHAR_CR  = 8'h0D;
    localparam logic [7:0]  CHAR_BS  = 8'h08;
    localparam logic [7:0]  CHAR_TAB = 8'h09;

    typedef enum logic [2:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_PUT,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_CLEAR_ROW
    } state_t;

endpackage

// File: rtl/terminal_writer.sv
// Turns a byte stream into terminal character-RAM writes, tracks the cursor,
// handles LF/CR/BS/TAB, scrolls by copying rows up and blanks the screen.
module terminal_writer
    import terminal_pkg::*;
#(
    parameter int         COLUMNS    = SCREEN_COLUMNS,
    parameter int         ROWS       = SCREEN_ROWS,
    parameter int         ADDR_WIDTH = SCREEN_ADDR_WIDTH,
    parameter logic [7:0] BLANK      = BLANK_CHAR
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  char_valid,
    input  logic [7:0]            char_data,
    output logic                  char_ready,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] text_addr,
    output logic                  text_write,
    output logic [7:0]            text_in,
    input  logic [7:0]            text_out,
    output logic [6:0]            cursor_x,
    output logic [4:0]            cursor_y,
    output logic                  busy
);

    // One extra bit so the scroll/clear-row source counter can run past the last cell.
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  CELLS    = CNT_W'(COLUMNS * ROWS);
    localparam logic [CNT_W-1:0]  CELLS_M1 = CNT_W'(COLUMNS * ROWS - 1);
    localparam logic [CNT_W-1:0]  COLS_C   = CNT_W'(COLUMNS);
    localparam logic [CNT_W-1:0]  ROW_END  = CNT_W'(COLUMNS * ROWS + COLUMNS - 1);
    localparam logic [7:0]        COLS_X   = 8'(COLUMNS);
    localparam logic [4:0]        LAST_Y   = 5'(ROWS - 1);

    state_t                state, state_n;
    logic [6:0]            x, x_n;
    logic [4:0]            y, y_n;
    logic [ADDR_WIDTH-1:0] row_base, row_base_n;
    logic [CNT_W-1:0]      src, src_n;
    logic [7:0]            data_q, data_n;
    logic                  pending, pending_n;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            inc_x;
    logic [7:0]            tab_x;
    logic                  newline;
    logic                  write_c;

    assign cur_addr = row_base + ADDR_WIDTH'(x);
    assign inc_x    = {1'b0, x} + 8'd1;
    assign tab_x    = ({1'b0, x} | 8'd7) + 8'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_CLEAR_ALL;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            src      <= '0;
            data_q   <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            row_base <= row_base_n;
            src      <= src_n;
            data_q   <= data_n;
            pending  <= pending_n;
        end
    end

    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        row_base_n = row_base;
        src_n      = src;
        data_n     = data_q;
        pending_n  = pending;
        newline    = 1'b0;
        text_addr  = cur_addr;
        write_c    = 1'b0;
        text_in    = BLANK;
        char_ready = 1'b0;

        // A clear arriving while busy is remembered and serviced at the next IDLE.
        if (state != ST_IDLE && clear) begin
            pending_n = 1'b1;
        end

        case (state)
            ST_CLEAR_ALL: begin
                text_addr = ADDR_WIDTH'(src);
                write_c   = 1'b1;
                if (src == CELLS_M1) begin
                    state_n    = ST_IDLE;
                    x_n        = '0;
                    y_n        = '0;
                    row_base_n = '0;
                    src_n      = '0;
                end else begin
                    src_n = src + 1'b1;
                end
            end

            ST_IDLE: begin
                char_ready = !clear && !pending;
                if (clear || pending) begin
                    state_n   = ST_CLEAR_ALL;
                    pending_n = 1'b0;
                    src_n     = '0;
                end else if (char_valid) begin
                    data_n  = char_data;
                    state_n = ST_PUT;
                end
            end

            ST_PUT: begin
                state_n = ST_IDLE;
                case (data_q)
                    CHAR_CR: x_n = '0;
                    CHAR_LF: begin
                        x_n     = '0;
                        newline = 1'b1;
                    end
                    CHAR_BS: begin
                        if (x != '0) begin
                            x_n       = x - 7'd1;
                            text_addr = cur_addr - ADDR_WIDTH'(1);
                            write_c   = 1'b1;
                        end
                    end
                    CHAR_TAB: begin
                        if (tab_x >= COLS_X) begin
                            x_n     = '0;
                            newline = 1'b1;
                        end else begin
                            x_n = tab_x[6:0];
                        end
                    end
                    default: begin
                        write_c = 1'b1;
                        text_in = data_q;
                        if (inc_x == COLS_X) begin
                            x_n     = '0;
                            newline = 1'b1;
                        end else begin
                            x_n = inc_x[6:0];
                        end
                    end
                endcase
                if (newline) begin
                    if (y < LAST_Y) begin
                        y_n        = y + 5'd1;
                        row_base_n = row_base + ADDR_WIDTH'(COLUMNS);
                    end else begin
                        state_n = ST_SCROLL_RD;
                        src_n   = COLS_C;
                    end
                end
            end

            ST_SCROLL_RD: begin
                text_addr = ADDR_WIDTH'(src);
                data_n    = text_out;
                state_n   = ST_SCROLL_WR;
            end

            ST_SCROLL_WR: begin
                text_addr = ADDR_WIDTH'(src - COLS_C);
                text_in   = data_q;
                write_c   = 1'b1;
                src_n     = src + 1'b1;
                state_n   = (src + 1'b1 == CELLS) ? ST_CLEAR_ROW : ST_SCROLL_RD;
            end

            // src continues from CELLS, so src-COLUMNS walks the last row.
            ST_CLEAR_ROW: begin
                text_addr = ADDR_WIDTH'(src - COLS_C);
                write_c   = 1'b1;
                src_n     = src + 1'b1;
                if (src == ROW_END) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_CLEAR_ALL;
                src_n   = '0;
            end
        endcase
    end

    // Reset also holds off the write strobe of the CLEAR_ALL state it forces.
    assign text_write = write_c && resetn;
    assign busy       = (state != ST_IDLE);
    assign cursor_x   = x;
    assign cursor_y   = y;

endmodule

// File: tb/tb_terminal_writer.sv
// Directed bench for terminal_writer: a RAM model behind the text port,
// a shadow screen, a table of character vectors and multi-cycle sequences.
module tb_terminal_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        clear = 1'b0;
    logic [11:0] text_addr;
    logic        text_write;
    logic [7:0]  text_in;
    logic [7:0]  text_out;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    terminal_writer dut (
        .clock      (clock),
        .resetn     (resetn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear      (clear),
        .text_addr  (text_addr),
        .text_write (text_write),
        .text_in    (text_in),
        .text_out   (text_out),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic [7:0]  ram [0:4095];
    logic [7:0]  exp_scr [0:CELLS-1];
    wr_t         wr_q[$];
    logic [19:0] exp_q[$];
    int          cyc = 0;
    int          nwrites = 0;
    int          total = 0;
    int          bad = 0;

    assign text_out = ram[text_addr];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (text_write) begin
            ram[text_addr] <= text_in;
            wr_q.push_back('{int'(text_addr), text_in, cyc});
            nwrites <= nwrites + 1;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic chk_cursor(input string name, input int ex, input int ey);
        chk({name, "_x"}, int'(cursor_x), ex);
        chk({name, "_y"}, int'(cursor_y), ey);
    endtask

    task automatic chk_screen(input string name);
        int diff = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (ram[i] !== exp_scr[i]) diff++;
        end
        chk({name, "_cells_differing"}, diff, 0);
    endtask

    task automatic blank_model();
        for (int i = 0; i < CELLS; i++) exp_scr[i] = 8'h20;
    endtask

    task automatic scroll_model();
        for (int i = 0; i < CELLS - COLS; i++) exp_scr[i] = exp_scr[i + COLS];
        for (int i = CELLS - COLS; i < CELLS; i++) exp_scr[i] = 8'h20;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_char(input logic [7:0] c, output int hs);
        int n = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (!char_ready && n < 10000) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready_seen", int'(char_ready), 1);
        hs = cyc;
        @(negedge clock);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_bound", int'(busy), 0);
    endtask

    task automatic send_idle(input logic [7:0] c);
        int hs, n;
        send_char(c, hs);
        wait_idle(n);
    endtask

    typedef struct {
        logic [7:0] ch;
        int         ex;
        int         ey;
        int         nwr;
        int         addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int hs, n, cnt, base, idle_seen;

        // Reset held: outputs forced quiet, cursor home.
        repeat (3) @(negedge clock);
        chk("rst_text_write", int'(text_write), 0);
        chk("rst_char_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk_cursor("rst_cursor", 0, 0);

        base = nwrites;
        resetn = 1'b1;
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            @(negedge clock);
        end
        chk("init_busy_cycles", cnt, 2400);
        chk("init_write_count", nwrites - base, 2400);
        blank_model();
        chk_screen("init_screen");
        chk("init_char_ready", int'(char_ready), 1);
        chk_cursor("init_cursor", 0, 0);

        vecs[0]  = '{8'h08,  0, 0, 0,   0, 8'h00};
        vecs[1]  = '{8'h41,  1, 0, 1,   0, 8'h41};
        vecs[2]  = '{8'h0D,  0, 0, 0,   0, 8'h00};
        vecs[3]  = '{8'h0A,  0, 1, 0,   0, 8'h00};
        vecs[4]  = '{8'h51,  1, 1, 1,  80, 8'h51};
        vecs[5]  = '{8'h0A,  0, 2, 0,   0, 8'h00};
        vecs[6]  = '{8'h0A,  0, 3, 0,   0, 8'h00};
        vecs[7]  = '{8'h68,  1, 3, 1, 240, 8'h68};
        vecs[8]  = '{8'h69,  2, 3, 1, 241, 8'h69};
        vecs[9]  = '{8'h78,  3, 3, 1, 242, 8'h78};
        vecs[10] = '{8'h79,  4, 3, 1, 243, 8'h79};
        vecs[11] = '{8'h7A,  5, 3, 1, 244, 8'h7A};
        vecs[12] = '{8'h08,  4, 3, 1, 244, 8'h20};
        vecs[13] = '{8'h08,  3, 3, 1, 243, 8'h20};
        vecs[14] = '{8'h0D,  0, 3, 0,   0, 8'h00};
        vecs[15] = '{8'h09,  8, 3, 0,   0, 8'h00};
        vecs[16] = '{8'h09, 16, 3, 0,   0, 8'h00};
        vecs[17] = '{8'h09, 24, 3, 0,   0, 8'h00};

        for (int i = 0; i < 18; i++) begin
            wr_q.delete();
            exp_q.delete();
            if (vecs[i].nwr == 1) begin
                exp_q.push_back({vecs[i].addr[11:0], vecs[i].data});
                exp_scr[vecs[i].addr] = vecs[i].data;
            end
            send_char(vecs[i].ch, hs);
            wait_idle(n);
            chk_cursor($sformatf("vec%0d_cursor", i), vecs[i].ex, vecs[i].ey);
            chk($sformatf("vec%0d_write_count", i), wr_q.size(), exp_q.size());
            if (wr_q.size() > 0 && exp_q.size() > 0) begin
                chk($sformatf("vec%0d_write_addr", i), wr_q[0].addr, int'(exp_q[0][19:8]));
                chk($sformatf("vec%0d_write_data", i), int'(wr_q[0].data), int'(exp_q[0][7:0]));
                chk($sformatf("vec%0d_write_cycle", i), wr_q[0].cyc - hs, 1);
            end
        end
        chk_screen("table_screen");

        // TAB from column 78 wraps to the next row without writing.
        send_idle(8'h0D);
        for (int i = 0; i < 9; i++) send_idle(8'h09);
        chk_cursor("tab9_cursor", 72, 3);
        for (int i = 0; i < 6; i++) begin
            send_idle(8'h61 + 8'(i));
            exp_scr[240 + 72 + i] = 8'h61 + 8'(i);
        end
        chk_cursor("pre_tab_cursor", 78, 3);
        wr_q.delete();
        send_idle(8'h09);
        chk_cursor("tab78_cursor", 0, 4);
        chk("tab78_write_count", wr_q.size(), 0);
        chk_screen("tab_screen");

        // Walk to the last row, then fill it to force a scroll.
        for (int i = 0; i < 25; i++) send_idle(8'h0A);
        chk_cursor("last_row_cursor", 0, 29);
        for (int i = 0; i < 80; i++) begin
            send_char(8'h21 + 8'(i), hs);
            exp_scr[29 * COLS + i] = 8'h21 + 8'(i);
            if (i < 79) wait_idle(n);
        end
        cnt = 0;
        while (busy && cnt < 6000) begin
            cnt++;
            @(negedge clock);
        end
        chk("scroll_busy_cycles", cnt, 4721);
        scroll_model();
        chk_screen("scroll_screen");
        chk_cursor("scroll_cursor", 0, 29);

        // Clear pulsed mid-scroll with a character waiting the whole time.
        send_char(8'h0A, hs);
        char_valid = 1'b1;
        char_data  = 8'h5A;
        repeat (100) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        idle_seen = 0;
        n = 0;
        while (!char_ready && n < 10000) begin
            if (!busy) idle_seen++;
            n++;
            @(negedge clock);
        end
        chk("clr_scroll_ready_seen", int'(char_ready), 1);
        chk("clr_scroll_idle_cycles", idle_seen, 1);
        chk_cursor("clr_scroll_cursor", 0, 0);
        blank_model();
        chk_screen("clr_scroll_screen");
        @(negedge clock);
        char_valid = 1'b0;
        wait_idle(n);
        exp_scr[0] = 8'h5A;
        chk_screen("clr_scroll_post_char");
        chk_cursor("clr_scroll_post_cursor", 1, 0);

        // Clear and a valid character in the same IDLE cycle: clear wins.
        clear      = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h4B;
        #1;
        chk("same_cycle_char_ready", int'(char_ready), 0);
        @(negedge clock);
        clear = 1'b0;
        chk("same_cycle_busy", int'(busy), 1);
        cnt = 0;
        n = 0;
        while (!char_ready && n < 5000) begin
            if (busy) cnt++;
            n++;
            @(negedge clock);
        end
        chk("same_cycle_clear_cycles", cnt, 2400);
        chk_cursor("same_cycle_cursor", 0, 0);
        chk("same_cycle_cell0_blank", int'(ram[0]), 8'h20);
        @(negedge clock);
        char_valid = 1'b0;
        wait_idle(n);
        chk("same_cycle_cell0_char", int'(ram[0]), 8'h4B);
        chk_cursor("same_cycle_post_cursor", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
